wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage.sv | 158 +++++++++++++++
 tb/tb_wb_stage.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage -- write-back pipeline register.
//
// Takes one instruction per cycle from the MEM stage, picks its write-back
// value, and registers the register-file write port.
//
// Write-back sources:
//   ALU result, load data, PC+4, or upper immediate.
//   Load data is the addressed byte, halfword or word lane of the raw memory
//   word, sign- or zero-extended.
//
// Parameters:
//   XLEN   datapath width, 32 or 64
//   RA_W   register-file address width
//   CNT_W  retired-instruction counter width
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   in_valid / in_ready            input handshake (in_ready = !stall)
//   in_src                         00 ALU, 01 MEM, 10 PC+4, 11 IMM
//   in_alu, in_mem, in_imm, in_pc  operand sources
//   in_ld_f3, in_addr_lo           load type and low address bits
//   in_rd, in_we                   destination register and write intent
//   flush                          drop the presented instruction
//   stall                          freeze the output register
//   rf_we, rf_waddr, rf_wdata      registered register-file write port
//   fwd_valid                      write port is a usable bypass source
//   retired                        count of instructions that transferred
// ---------------------------------------------------------------------------
module wb_stage #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_src,
    input  logic [XLEN-1:0]  in_alu,
    input  logic [XLEN-1:0]  in_mem,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [2:0]       in_ld_f3,
    input  logic [2:0]       in_addr_lo,
    input  logic [RA_W-1:0]  in_rd,
    input  logic             in_we,
    input  logic             flush,
    input  logic             stall,
    output logic             rf_we,
    output logic [RA_W-1:0]  rf_waddr,
    output logic [XLEN-1:0]  rf_wdata,
    output logic             fwd_valid,
    output logic [CNT_W-1:0] retired
);

    localparam logic IS64 = (XLEN == 64);

    logic             rf_we_q,    rf_we_d;
    logic [RA_W-1:0]  rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]  rf_wdata_q, rf_wdata_d;
    logic [CNT_W-1:0] retired_q,  retired_d;

    logic             xfer;
    logic [63:0]      mem64;
    logic [5:0]       shamt_b, shamt_h, shamt_w;
    logic [7:0]       lane_b;
    logic [15:0]      lane_h;
    logic [31:0]      lane_w;
    logic [63:0]      ld64;
    logic             ld_illegal;
    logic [XLEN-1:0]  wb_value;
    logic             wb_we;

    assign in_ready = !stall;
    assign xfer     = in_valid && !stall && !flush;

    // Lane extraction is done on a 64-bit view so both XLEN builds share one
    // datapath; on XLEN=32 the lane-select MSB is forced low, which also drops
    // the misaligned low bits for halfword and word accesses.
    assign mem64   = 64'(in_mem);
    assign shamt_b = {in_addr_lo[2] & IS64, in_addr_lo[1:0], 3'b000};
    assign shamt_h = {in_addr_lo[2] & IS64, in_addr_lo[1], 4'b0000};
    assign shamt_w = {in_addr_lo[2] & IS64, 5'b00000};
    assign lane_b  = mem64[shamt_b +: 8];
    assign lane_h  = mem64[shamt_h +: 16];
    assign lane_w  = mem64[shamt_w +: 32];

    assign ld_illegal = (in_ld_f3 == 3'b111) ||
                        (!IS64 && ((in_ld_f3 == 3'b011) || (in_ld_f3 == 3'b110)));

    always_comb begin
        ld64 = '0;
        case (in_ld_f3)
            3'b000:  ld64 = {{56{lane_b[7]}}, lane_b};
            3'b001:  ld64 = {{48{lane_h[15]}}, lane_h};
            3'b010:  ld64 = {{32{lane_w[31]}}, lane_w};
            3'b100:  ld64 = {56'd0, lane_b};
            3'b101:  ld64 = {48'd0, lane_h};
            3'b110:  ld64 = {32'd0, lane_w};
            3'b011:  ld64 = mem64;
            default: ld64 = '0;
        endcase
    end

    always_comb begin
        wb_value = '0;
        case (in_src)
            2'b00:   wb_value = in_alu;
            2'b01:   wb_value = ld_illegal ? '0 : XLEN'(ld64);
            2'b10:   wb_value = in_pc + XLEN'(4);
            default: wb_value = in_imm;
        endcase
    end

    // x0 writes still carry their data; only the enable is dropped.
    assign wb_we = in_we && (in_rd != '0) && !((in_src == 2'b01) && ld_illegal);

    always_comb begin
        rf_we_d    = rf_we_q;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        retired_d  = retired_q;
        if (!stall) begin
            if (xfer) begin
                rf_we_d    = wb_we;
                rf_waddr_d = in_rd;
                rf_wdata_d = wb_value;
                retired_d  = retired_q + CNT_W'(1);
            end else begin
                rf_we_d    = 1'b0;
                rf_waddr_d = '0;
                rf_wdata_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            retired_q  <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            retired_q  <= retired_d;
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign fwd_valid = rf_we_q && (rf_waddr_q != '0);
    assign retired   = retired_q;

endmodule

// File: tb/tb_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_wb_stage -- self-checking bench for wb_stage.
//
// Two instances share one set of inputs:
//   u_dut32  XLEN=32, CNT_W=32
//   u_dut64  XLEN=64, CNT_W=4 (small counter so wrap-around is reached)
//
// Expected values come from a behavioural model written directly from the
// load/extend rules with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [1:0]  in_src;
    logic [63:0] in_alu, in_mem, in_imm, in_pc;
    logic [2:0]  in_ld_f3, in_addr_lo;
    logic [4:0]  in_rd;
    logic        in_we, flush, stall;

    logic        rdy32, we32, fwd32;
    logic [4:0]  wa32;
    logic [31:0] wd32, ret32;
    logic        rdy64, we64, fwd64;
    logic [4:0]  wa64;
    logic [63:0] wd64;
    logic [3:0]  ret64;

    int checks = 0;
    int errors = 0;

    // model state: index 0 = 32-bit instance, 1 = 64-bit instance
    logic        e_we   [2];
    logic [4:0]  e_addr [2];
    logic [63:0] e_data [2];
    logic [31:0] e_ret32;
    logic [3:0]  e_ret4;

    wb_stage #(.XLEN(32), .RA_W(5), .CNT_W(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
        .in_src(in_src), .in_alu(in_alu[31:0]), .in_mem(in_mem[31:0]),
        .in_imm(in_imm[31:0]), .in_pc(in_pc[31:0]), .in_ld_f3(in_ld_f3),
        .in_addr_lo(in_addr_lo), .in_rd(in_rd), .in_we(in_we), .flush(flush),
        .stall(stall), .rf_we(we32), .rf_waddr(wa32), .rf_wdata(wd32),
        .fwd_valid(fwd32), .retired(ret32)
    );

    wb_stage #(.XLEN(64), .RA_W(5), .CNT_W(4)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy64),
        .in_src(in_src), .in_alu(in_alu), .in_mem(in_mem),
        .in_imm(in_imm), .in_pc(in_pc), .in_ld_f3(in_ld_f3),
        .in_addr_lo(in_addr_lo), .in_rd(in_rd), .in_we(in_we), .flush(flush),
        .stall(stall), .rf_we(we64), .rf_waddr(wa64), .rf_wdata(wd64),
        .fwd_valid(fwd64), .retired(ret64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic m_legal(int xl, logic [2:0] f);
        if (f == 3'd7) return 1'b0;
        if (xl == 32 && (f == 3'd3 || f == 3'd6)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [63:0] m_wdata(int xl);
        logic [63:0] mask, mm, b, h, w, r;
        int boff, hoff, woff;
        mask = (xl == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        mm   = in_mem & mask;
        boff = (xl == 32) ? int'(in_addr_lo) % 4       : int'(in_addr_lo);
        hoff = (xl == 32) ? (int'(in_addr_lo) / 2) % 2 : int'(in_addr_lo) / 2;
        woff = (xl == 32) ? 0                          : int'(in_addr_lo) / 4;
        b = (mm >> (8 * boff))  & 64'hFF;
        h = (mm >> (16 * hoff)) & 64'hFFFF;
        w = (mm >> (32 * woff)) & 64'hFFFF_FFFF;
        case (in_src)
            2'd0: r = in_alu;
            2'd2: r = in_pc + 64'd4;
            2'd3: r = in_imm;
            default: begin
                case (in_ld_f3)
                    3'd0:    r = b[7]  ? (b | ~64'hFF)        : b;
                    3'd1:    r = h[15] ? (h | ~64'hFFFF)      : h;
                    3'd2:    r = w[31] ? (w | ~64'hFFFF_FFFF) : w;
                    3'd4:    r = b;
                    3'd5:    r = h;
                    3'd6:    r = w;
                    3'd3:    r = mm;
                    default: r = 64'd0;
                endcase
                if (!m_legal(xl, in_ld_f3)) r = 64'd0;
            end
        endcase
        return r & mask;
    endfunction

    function automatic logic m_we(int xl);
        if (!in_we || in_rd == 5'd0) return 1'b0;
        if (in_src == 2'd1 && !m_legal(xl, in_ld_f3)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".rdy32"}, 64'(rdy32), 64'(!stall));
        chk({tag, ".we32"},  64'(we32),  64'(e_we[0]));
        chk({tag, ".wa32"},  64'(wa32),  64'(e_addr[0]));
        chk({tag, ".wd32"},  64'(wd32),  e_data[0]);
        chk({tag, ".fwd32"}, 64'(fwd32), 64'(e_we[0] && e_addr[0] != 5'd0));
        chk({tag, ".ret32"}, 64'(ret32), 64'(e_ret32));
        chk({tag, ".we64"},  64'(we64),  64'(e_we[1]));
        chk({tag, ".wa64"},  64'(wa64),  64'(e_addr[1]));
        chk({tag, ".wd64"},  wd64,       e_data[1]);
        chk({tag, ".fwd64"}, 64'(fwd64), 64'(e_we[1] && e_addr[1] != 5'd0));
        chk({tag, ".ret64"}, 64'(ret64), 64'(e_ret4));
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            e_we[k] = 1'b0; e_addr[k] = 5'd0; e_data[k] = 64'd0;
        end
        e_ret32 = 32'd0;
        e_ret4  = 4'd0;
    endtask

    // Advance one clock with the inputs currently driven, then check.
    task automatic step(input string tag);
        if (!stall) begin
            if (in_valid && !flush) begin
                e_data[0] = m_wdata(32); e_we[0] = m_we(32); e_addr[0] = in_rd;
                e_data[1] = m_wdata(64); e_we[1] = m_we(64); e_addr[1] = in_rd;
                e_ret32++;
                e_ret4++;
            end else begin
                for (int k = 0; k < 2; k++) begin
                    e_we[k] = 1'b0; e_addr[k] = 5'd0; e_data[k] = 64'd0;
                end
            end
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic load(input logic [63:0] mem, input logic [2:0] f3,
                        input logic [2:0] lo, input logic [4:0] rd);
        in_valid = 1'b1; in_src = 2'd1; in_mem = mem; in_ld_f3 = f3;
        in_addr_lo = lo; in_rd = rd; in_we = 1'b1; flush = 1'b0; stall = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_src = 2'd0; in_alu = '0; in_mem = '0; in_imm = '0;
        in_pc = '0; in_ld_f3 = 3'd0; in_addr_lo = 3'd0; in_rd = 5'd0;
        in_we = 1'b0; flush = 1'b0; stall = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step("idle");

        // byte loads, signed
        load(64'hA5A5_A5A5_80FF_7F01, 3'd0, 3'd1, 5'd3);
        step("lb1");
        chk("lb1.const", 64'(wd32), 64'h0000_007F);
        in_addr_lo = 3'd2;
        step("lb2");
        chk("lb2.const", 64'(wd32), 64'hFFFF_FFFF);

        // halfword loads
        load(64'h0000_0000_8001_1234, 3'd5, 3'd2, 5'd4);
        step("lhu");
        chk("lhu.const", 64'(wd32), 64'h0000_8001);
        in_ld_f3 = 3'd1;
        step("lh");
        chk("lh.const", 64'(wd32), 64'hFFFF_8001);

        // PC+4 wrap and x0 suppression
        in_src = 2'd2; in_pc = 64'h0000_0000_FFFF_FFFC; in_rd = 5'd5;
        step("pc4");
        chk("pc4.wd", 64'(wd32), 64'h0);
        chk("pc4.we", 64'(we32), 64'h1);
        chk("pc4.fwd", 64'(fwd32), 64'h1);
        in_rd = 5'd0;
        step("pc4x0");
        chk("pc4x0.fwd", 64'(fwd32), 64'h0);

        // 64-bit word lanes; illegal f3 on the 32-bit build
        load(64'hDEAD_BEEF_8000_0000, 3'd6, 3'd4, 5'd7);
        step("lwu");
        chk("lwu.const", wd64, 64'h0000_0000_DEAD_BEEF);
        chk("lwu.ill32", 64'(we32), 64'h0);
        in_ld_f3 = 3'd2;
        step("lw");
        chk("lw.const", wd64, 64'hFFFF_FFFF_DEAD_BEEF);
        in_ld_f3 = 3'd7;
        step("f3ill");

        // Stall holds A while flush and valid are asserted
        in_src = 2'd0; in_alu = 64'h1111_2222_3333_4444; in_rd = 5'd9; in_we = 1'b1;
        in_valid = 1'b1;
        step("A");
        stall = 1'b1; flush = 1'b1; in_alu = 64'h5555;
        for (int i = 0; i < 3; i++) step("stall");
        stall = 1'b0; flush = 1'b0; in_alu = 64'h6666; in_rd = 5'd10;
        step("release");
        flush = 1'b1;
        step("flush");
        flush = 1'b0; in_valid = 1'b0;
        step("bubble");

        // Reset asserted mid-transfer, between edges
        in_valid = 1'b1; in_alu = 64'h7777; in_rd = 5'd11;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("rst_async");
        @(posedge clk);
        #1;
        check_all("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        in_alu = 64'h8888; in_rd = 5'd12;
        step("post_rst");

        // Randomized traffic; retired on the 4-bit counter wraps repeatedly
        for (int n = 0; n < 400; n++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 6) == 0);
            stall      = ($urandom_range(0, 4) == 0);
            in_src     = 2'($urandom_range(0, 3));
            in_alu     = {$urandom, $urandom};
            in_mem     = {$urandom, $urandom};
            in_imm     = {$urandom, $urandom};
            in_pc      = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC
                                                     : {$urandom, $urandom};
            in_ld_f3   = 3'($urandom_range(0, 7));
            in_addr_lo = 3'($urandom_range(0, 7));
            in_rd      = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            in_we      = ($urandom_range(0, 4) != 0);
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
